spi_burst_scheduler: RTL and testbench

- Serial-domain frame scheduler that shares one SPI link among NUM_REQ requesters.
- Round-robin arbitration; loads the winner's word, drives ss_n/mosi, shifts DATA_W bits LSB-first, and captures miso into a received word tagged with its owner.
- Sits between requester logic and the SPI pins, clocked by the mode-adjusted serial clock, so every state step is one serial bit time.

---
 rtl/spi_sched_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/spi_burst_scheduler.sv | 140 ++++++++++++++
 tb/tb_spi_burst_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sched_pkg.sv
// Shared types and helpers for the SPI burst scheduler.
// Holds the FSM state encoding, default sizes and round-robin step.
package spi_sched_pkg;

  localparam int DATA_W_DEF = 18;
  localparam int GAP_DEF    = 2;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after
// the pointer, wrapping; the pointer register lives in the scheduler.
module rr_arbiter
  import spi_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [PW-1:0]      o_idx,
  output logic               o_any
);

  logic [PW-1:0] w_cand;

  always_comb begin
    o_any  = 1'b0;
    o_idx  = '0;
    o_gnt  = '0;
    w_cand = i_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!o_any && i_req[w_cand]) begin
        o_any = 1'b1;
        o_idx = w_cand;
      end
      w_cand = PW'(rr_next(int'(w_cand), NUM_REQ));
    end
    if (o_any) o_gnt[o_idx] = 1'b1;
  end

endmodule

// File: rtl/spi_burst_scheduler.sv
// Round-robin SPI frame scheduler, LSB-first, one state step per bit time.
// Define SPI_BURST_CHAIN_EN to chain pending frames without an ss_n gap.
module spi_burst_scheduler
  import spi_sched_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_REQ    = 2,
  parameter int GAP_CYCLES = GAP_DEF
) (
  input  logic                        modified_sclk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic                        miso,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        ss_n,
  output logic                        mosi,
  output logic [DATA_W-1:0]           rx_data,
  output logic                        rx_valid,
  output logic [$clog2(NUM_REQ)-1:0]  rx_owner,
  output logic                        busy
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int BW = $clog2(DATA_W);
  // The IDLE arbitration slot supplies the last ss_n-high bit time.
  localparam int GAP_LAST = (GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0;
`ifdef SPI_BURST_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  state_t              r_state;
  logic [BW-1:0]       r_bit_cnt;
  logic [3:0]          r_gap_cnt;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       r_owner;
  logic [DATA_W-2:0]   r_tx_sh;
  logic [DATA_W-2:0]   r_rx_sh;
  logic [NUM_REQ-1:0]  r_grant;
  logic                r_ss_n;
  logic                r_mosi;
  logic [DATA_W-1:0]   r_rx_data;
  logic                r_rx_valid;
  logic [PW-1:0]       r_rx_owner;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [PW-1:0]       w_idx;
  logic                w_any;
  logic                w_last;
  logic                w_load;
  logic [DATA_W-1:0]   w_word;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_arb (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_word = req_data[int'(w_idx)*DATA_W +: DATA_W];
  assign w_last = (r_state == SHIFT) &&
                  (r_bit_cnt == BW'(DATA_W - 1));
  assign w_load = w_any &&
                  ((r_state == IDLE) || (CHAIN && w_last));

  always_ff @(posedge modified_sclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_tx_sh    <= '1;
      r_rx_sh    <= '1;
      r_grant    <= '0;
      r_ss_n     <= 1'b1;
      r_mosi     <= 1'b1;
      r_rx_data  <= '1;
      r_rx_valid <= 1'b0;
      r_rx_owner <= '0;
    end else begin
      r_grant    <= '0;
      r_rx_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_ss_n <= 1'b1;
          r_mosi <= 1'b1;
        end
        SHIFT: begin
          r_rx_sh   <= {miso, r_rx_sh[DATA_W-2:1]};
          r_tx_sh   <= {1'b1, r_tx_sh[DATA_W-2:1]};
          r_mosi    <= r_tx_sh[0];
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (w_last) begin
            r_rx_data  <= {miso, r_rx_sh};
            r_rx_owner <= r_owner;
            r_rx_valid <= 1'b1;
            r_ss_n     <= 1'b1;
            r_mosi     <= 1'b1;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_state    <= (GAP_CYCLES > 1) ? GAP : IDLE;
          end
        end
        GAP: begin
          r_ss_n    <= 1'b1;
          r_gap_cnt <= r_gap_cnt + 1'b1;
          if (r_gap_cnt == 4'(GAP_LAST)) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // A load overrides the end-of-frame defaults when chaining.
      if (w_load) begin
        r_grant   <= w_gnt;
        r_tx_sh   <= w_word[DATA_W-1:1];
        r_mosi    <= w_word[0];
        r_owner   <= w_idx;
        r_ss_n    <= 1'b0;
        r_bit_cnt <= '0;
        r_ptr     <= PW'(rr_next(int'(w_idx), NUM_REQ));
        r_state   <= SHIFT;
      end
    end
  end

  assign grant    = r_grant;
  assign ss_n     = r_ss_n;
  assign mosi     = r_mosi;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign rx_owner = r_rx_owner;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_spi_burst_scheduler.sv
// Directed self-checking bench for spi_burst_scheduler.
// Samples on the falling edge; inputs change right after sampling.
module tb_spi_burst_scheduler;

  localparam int DW = 18;
  localparam int NR = 2;

  logic            clk;
  logic            reset_n;
  logic [NR-1:0]   req;
  logic [NR*DW-1:0] req_data;
  logic            miso;
  logic [NR-1:0]   grant;
  logic            ss_n;
  logic            mosi;
  logic [DW-1:0]   rx_data;
  logic            rx_valid;
  logic            rx_owner;
  logic            busy;

  logic            loop_en;
  logic            miso_fixed;

  int n_checks;
  int n_fail;

  logic [NR-1:0] q_grant[$];
  logic [DW-1:0] q_rxd[$];
  logic          q_rxo[$];
  int            q_low[$];
  int            q_high[$];
  logic          q_mosi[$];
  int            n_coin;
  int            grants_left;
  logic          prev_ss;
  int            run_len;
  bit            seen_low;

  assign miso = loop_en ? mosi : miso_fixed;

  spi_burst_scheduler #(
    .DATA_W     (DW),
    .NUM_REQ    (NR),
    .GAP_CYCLES (2)
  ) dut (
    .modified_sclk (clk),
    .reset_n       (reset_n),
    .req           (req),
    .req_data      (req_data),
    .miso          (miso),
    .grant         (grant),
    .ss_n          (ss_n),
    .mosi          (mosi),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_owner      (rx_owner),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_mon();
    q_grant.delete();
    q_rxd.delete();
    q_rxo.delete();
    q_low.delete();
    q_high.delete();
    q_mosi.delete();
    n_coin   = 0;
    prev_ss  = 1'b1;
    run_len  = 0;
    seen_low = 1'b0;
  endtask

  task automatic run_window(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (grant !== '0) begin
        q_grant.push_back(grant);
        if (rx_valid === 1'b1) n_coin++;
        if (grants_left > 0) begin
          grants_left--;
          if (grants_left == 0) req = '0;
        end
      end
      if (rx_valid === 1'b1) begin
        q_rxd.push_back(rx_data);
        q_rxo.push_back(rx_owner);
      end
      if (ss_n === 1'b0) q_mosi.push_back(mosi);
      if (ss_n === prev_ss) run_len++;
      else begin
        if (prev_ss == 1'b0) begin
          q_low.push_back(run_len);
          seen_low = 1'b1;
        end else if (seen_low) q_high.push_back(run_len);
        prev_ss = ss_n;
        run_len = 1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ss_n !== 1'b1 || mosi !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pins: ss_n=%b mosi=%b want 1 1", ss_n, mosi);
    end
    n_checks++;
    if (grant !== 2'b00 || rx_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: grant=%b rx_valid=%b busy=%b want 00 0 0",
               grant, rx_valid, busy);
    end
    n_checks++;
    if (rx_data !== 18'h3FFFF || rx_owner !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rx: rx_data=%h owner=%b want 3ffff 0",
               rx_data, rx_owner);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [DW-1:0] w;
    clear_mon();
    loop_en     = 1'b1;
    req_data    = {18'h00000, 18'h2A5A5};
    req         = 2'b01;
    grants_left = 1;
    run_window(40);
    w = '0;
    for (int i = 0; i < DW && i < q_mosi.size(); i++) w[i] = q_mosi[i];
    n_checks++;
    if (q_grant.size() != 1 || q_grant[0] !== 2'b01) begin
      n_fail++;
      $display("FAIL single_grant: pulses=%0d first=%b want 1 01",
               q_grant.size(), q_grant.size() ? q_grant[0] : 2'bxx);
    end
    n_checks++;
    if (q_low.size() != 1 || q_low[0] != 18) begin
      n_fail++;
      $display("FAIL single_ss_low: runs=%0d len=%0d want 1 18",
               q_low.size(), q_low.size() ? q_low[0] : -1);
    end
    n_checks++;
    if (q_mosi.size() != DW || w !== 18'h2A5A5) begin
      n_fail++;
      $display("FAIL single_mosi: bits=%0d word=%h want 18 2a5a5",
               q_mosi.size(), w);
    end
    n_checks++;
    if (q_rxd.size() != 1 || q_rxd[0] !== 18'h2A5A5 || q_rxo[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_rx: pulses=%0d data=%h want 1 2a5a5 owner 0",
               q_rxd.size(), q_rxd.size() ? q_rxd[0] : 18'hx);
    end
    n_checks++;
    if (busy !== 1'b0 || ss_n !== 1'b1) begin
      n_fail++;
      $display("FAIL single_idle: busy=%b ss_n=%b want 0 1", busy, ss_n);
    end
  endtask

  task automatic test_contention();
    do_reset();
    clear_mon();
    loop_en     = 1'b1;
    req_data    = {18'h3ABCD, 18'h12345};
    req         = 2'b11;
    grants_left = 3;
    run_window(80);
    n_checks++;
    if (q_grant.size() != 3 || q_grant[0] !== 2'b01 ||
        q_grant[1] !== 2'b10 || q_grant[2] !== 2'b01) begin
      n_fail++;
      $display("FAIL rr_grants: n=%0d got %b %b %b want 01 10 01",
               q_grant.size(), q_grant[0], q_grant[1], q_grant[2]);
    end
    n_checks++;
    if (q_rxo.size() != 3 || q_rxo[0] !== 1'b0 ||
        q_rxo[1] !== 1'b1 || q_rxo[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_owners: n=%0d got %b %b %b want 0 1 0",
               q_rxo.size(), q_rxo[0], q_rxo[1], q_rxo[2]);
    end
    n_checks++;
    if (q_rxd.size() != 3 || q_rxd[0] !== 18'h12345 ||
        q_rxd[1] !== 18'h3ABCD || q_rxd[2] !== 18'h12345) begin
      n_fail++;
      $display("FAIL rr_data: got %h %h %h want 12345 3abcd 12345",
               q_rxd[0], q_rxd[1], q_rxd[2]);
    end
  endtask

  task automatic test_gap();
    clear_mon();
    loop_en     = 1'b1;
    req_data    = {18'h0F0F3, 18'h00000};
    req         = 2'b10;
    grants_left = 2;
    run_window(60);
    n_checks++;
    if (q_grant.size() != 2 || q_grant[0] !== 2'b10 || q_grant[1] !== 2'b10) begin
      n_fail++;
      $display("FAIL gap_grants: n=%0d want 2 grants of 10", q_grant.size());
    end
`ifdef SPI_BURST_CHAIN_EN
    n_checks++;
    if (q_low.size() != 1 || q_low[0] != 36) begin
      n_fail++;
      $display("FAIL chain_ss_low: runs=%0d len=%0d want 1 36",
               q_low.size(), q_low.size() ? q_low[0] : -1);
    end
    n_checks++;
    if (n_coin != 1) begin
      n_fail++;
      $display("FAIL chain_coincide: got %0d want 1", n_coin);
    end
`else
    n_checks++;
    if (q_high.size() != 1 || q_high[0] != 2) begin
      n_fail++;
      $display("FAIL gap_ss_high: runs=%0d len=%0d want 1 2",
               q_high.size(), q_high.size() ? q_high[0] : -1);
    end
    n_checks++;
    if (q_low.size() != 2 || q_low[0] != 18 || q_low[1] != 18 || n_coin != 0) begin
      n_fail++;
      $display("FAIL gap_frames: runs=%0d coin=%0d want 2x18 0",
               q_low.size(), n_coin);
    end
`endif
    n_checks++;
    if (q_rxd.size() != 2 || q_rxd[1] !== 18'h0F0F3 || q_rxo[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_rx: n=%0d want 2 frames 0f0f3 owner 1", q_rxd.size());
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    loop_en  = 1'b1;
    req_data = {18'h3FFFF, 18'h15555};
    req      = 2'b01;
    got      = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (grant !== '0) got = 1'b1;
    end
    req = '0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL mid_grant_timeout: got none want grant within 10");
    end
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (ss_n !== 1'b1 || mosi !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async: ss_n=%b mosi=%b busy=%b want 1 1 0",
               ss_n, mosi, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    clear_mon();
    grants_left = 0;
    run_window(25);
    n_checks++;
    if (q_rxd.size() != 0 || q_low.size() != 0 || ss_n !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_discard: rx=%0d lows=%0d ss_n=%b want 0 0 1",
               q_rxd.size(), q_low.size(), ss_n);
    end
    clear_mon();
    req         = 2'b11;
    grants_left = 1;
    run_window(30);
    n_checks++;
    if (q_grant.size() < 1 || q_grant[0] !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_ptr: first=%b want 01",
               q_grant.size() ? q_grant[0] : 2'bxx);
    end
  endtask

  task automatic test_all_ones();
    logic [DW-1:0] w;
    clear_mon();
    loop_en     = 1'b0;
    miso_fixed  = 1'b1;
    req_data    = {18'h2AAAA, 18'h00000};
    req         = 2'b01;
    grants_left = 1;
    run_window(30);
    w = '1;
    for (int i = 0; i < DW && i < q_mosi.size(); i++) w[i] = q_mosi[i];
    n_checks++;
    if (q_mosi.size() != DW || w !== 18'h00000) begin
      n_fail++;
      $display("FAIL ones_mosi: bits=%0d word=%h want 18 00000",
               q_mosi.size(), w);
    end
    n_checks++;
    if (q_rxd.size() != 1 || q_rxd[0] !== 18'h3FFFF) begin
      n_fail++;
      $display("FAIL ones_rx: n=%0d data=%h want 1 3ffff",
               q_rxd.size(), q_rxd.size() ? q_rxd[0] : 18'hx);
    end
    loop_en = 1'b1;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    req         = '0;
    req_data    = '0;
    loop_en     = 1'b1;
    miso_fixed  = 1'b0;
    grants_left = 0;
    reset_n     = 1'b0;
    clear_mon();
    test_reset();
    test_single();
    test_contention();
    test_gap();
    test_reset_mid();
    test_all_ones();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
